// File: rtl/pifo_pkg.sv
// Shared types and helpers for the prefetch refill controller.
package pifo_pkg;

    // Refill FSM: arbitrate, request, wait for the single outstanding response, push.
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRsp,
        StPush
    } refill_state_t;

    // Increment modulo n.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
module rr_arbiter #(
    parameter int unsigned NUM_FLOWS = 16,
    parameter int unsigned IDX_WIDTH = $clog2(NUM_FLOWS + 1)
) (
    input  logic [NUM_FLOWS-1:0] req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 gnt_valid,
    output logic [IDX_WIDTH-1:0] gnt_idx
);

    logic [NUM_FLOWS-1:0] rot;
    int unsigned          pos;

    // Rotate so that bit 0 corresponds to the flow at ptr.
    assign rot = NUM_FLOWS'({req, req} >> ptr);

    // Lowest set bit of the rotated vector, mapped back to a flow index.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        pos       = 0;
        for (int unsigned k = 0; k < NUM_FLOWS; k++) begin
            if (!gnt_valid && rot[k]) begin
                gnt_valid = 1'b1;
                pos       = 32'(ptr) + k;
                if (pos >= NUM_FLOWS) begin
                    pos = pos - NUM_FLOWS;
                end
                gnt_idx = IDX_WIDTH'(pos);
            end
        end
    end

endmodule

// File: rtl/prefetch_refill_ctrl.sv
// Refill controller: tracks per-flow backlog and prefetch occupancy, and moves one
// element at a time from the backing store into the prefetch buffer.
module prefetch_refill_ctrl
    import pifo_pkg::*;
#(
    parameter int unsigned NUM_FLOWS     = 16,
    parameter int unsigned DEPTH         = 1,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned BACKLOG_WIDTH = 8,
    localparam int unsigned IDX_WIDTH    = $clog2(NUM_FLOWS + 1),
    localparam int unsigned CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i__enq_valid,
    input  logic [IDX_WIDTH-1:0]  i__enq_flow_id,
    output logic                  o__enq_overflow,
    output logic                  o__fetch_req_valid,
    output logic [IDX_WIDTH-1:0]  o__fetch_req_flow_id,
    input  logic                  i__fetch_req_ready,
    input  logic                  i__fetch_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i__fetch_rsp_data,
    output logic                  o__push_valid,
    output logic [IDX_WIDTH-1:0]  o__push_flow_id,
    output logic [DATA_WIDTH-1:0] o__push_data,
    input  logic                  i__pop,
    input  logic [IDX_WIDTH-1:0]  i__pop_flow_id,
    input  logic                  i__reinsert_valid,
    output logic                  o__pop_underflow,
    output logic                  o__busy
);

    refill_state_t           state_q, state_d;
    logic [IDX_WIDTH-1:0]    flow_q, flow_d;
    logic [IDX_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [BACKLOG_WIDTH-1:0] backlog_q [NUM_FLOWS];
    logic [BACKLOG_WIDTH-1:0] backlog_d [NUM_FLOWS];
    logic [CNT_WIDTH-1:0]    occ_q [NUM_FLOWS];
    logic [CNT_WIDTH-1:0]    occ_d [NUM_FLOWS];
    logic                    enq_overflow_q, enq_overflow_d;
    logic                    pop_underflow_q, pop_underflow_d;

    logic [NUM_FLOWS-1:0]    eligible;
    logic [NUM_FLOWS-1:0]    enq_hit, acc_hit, pop_hit;
    logic                    enq_ok, pop_ok, req_accept;
    logic                    grant_valid;
    logic [IDX_WIDTH-1:0]    grant_idx;

    // Out-of-range flow ids are dropped at the boundary.
    assign enq_ok     = i__enq_valid && (i__enq_flow_id < IDX_WIDTH'(NUM_FLOWS));
    assign pop_ok     = i__pop && (i__pop_flow_id < IDX_WIDTH'(NUM_FLOWS));
    assign req_accept = (state_q == StReq) && i__fetch_req_ready;

    // Per-flow decode of the three counter events and eligibility from registered counts.
    always_comb begin
        for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
            enq_hit[f]  = enq_ok && (i__enq_flow_id == IDX_WIDTH'(f));
            acc_hit[f]  = req_accept && (flow_q == IDX_WIDTH'(f));
            pop_hit[f]  = pop_ok && (i__pop_flow_id == IDX_WIDTH'(f));
            eligible[f] = (backlog_q[f] != '0) && (occ_q[f] < CNT_WIDTH'(DEPTH));
        end
    end

    rr_arbiter #(
        .NUM_FLOWS (NUM_FLOWS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_arbiter (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .gnt_valid (grant_valid),
        .gnt_idx   (grant_idx)
    );

    // Backlog and occupancy next state; simultaneous inc/dec on a flow cancel out.
    always_comb begin
        enq_overflow_d  = 1'b0;
        pop_underflow_d = 1'b0;
        for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
            backlog_d[f] = backlog_q[f];
            occ_d[f]     = occ_q[f];

            if (enq_hit[f] && !acc_hit[f]) begin
                if (backlog_q[f] == '1) begin
                    enq_overflow_d = 1'b1;
                end else begin
                    backlog_d[f] = backlog_q[f] + BACKLOG_WIDTH'(1);
                end
            end else if (acc_hit[f] && !enq_hit[f]) begin
                backlog_d[f] = backlog_q[f] - BACKLOG_WIDTH'(1);
            end

            if (pop_hit[f] && (occ_q[f] == '0)) begin
                pop_underflow_d = 1'b1;
            end
            // A pop on an empty flow is clamped; a reinserted pop keeps its slot.
            if (acc_hit[f] && !(pop_hit[f] && !i__reinsert_valid && (occ_q[f] != '0))) begin
                occ_d[f] = occ_q[f] + CNT_WIDTH'(1);
            end else if (!acc_hit[f] && pop_hit[f] && !i__reinsert_valid &&
                         (occ_q[f] != '0)) begin
                occ_d[f] = occ_q[f] - CNT_WIDTH'(1);
            end
        end
    end

    // FSM next state and latched flow/data/pointer.
    always_comb begin
        state_d  = state_q;
        flow_d   = flow_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    flow_d  = grant_idx;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (i__fetch_req_ready) begin
                    rr_ptr_d = IDX_WIDTH'(wrap_inc(32'(flow_q), NUM_FLOWS));
                    state_d  = StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (i__fetch_rsp_valid) begin
                    data_d  = i__fetch_rsp_data;
                    state_d = StPush;
                end
            end
            StPush: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset also abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            flow_q          <= '0;
            data_q          <= '0;
            rr_ptr_q        <= '0;
            enq_overflow_q  <= 1'b0;
            pop_underflow_q <= 1'b0;
            for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
                backlog_q[f] <= '0;
                occ_q[f]     <= '0;
            end
        end else begin
            state_q         <= state_d;
            flow_q          <= flow_d;
            data_q          <= data_d;
            rr_ptr_q        <= rr_ptr_d;
            enq_overflow_q  <= enq_overflow_d;
            pop_underflow_q <= pop_underflow_d;
            for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
                backlog_q[f] <= backlog_d[f];
                occ_q[f]     <= occ_d[f];
            end
        end
    end

    // Outputs decode from state only; ids and data read as zero when not valid.
    always_comb begin
        o__fetch_req_valid   = (state_q == StReq);
        o__fetch_req_flow_id = (state_q == StReq) ? flow_q : '0;
        o__push_valid        = (state_q == StPush);
        o__push_flow_id      = (state_q == StPush) ? flow_q : '0;
        o__push_data         = (state_q == StPush) ? data_q : '0;
        o__busy              = (state_q != StIdle);
        o__enq_overflow      = enq_overflow_q;
        o__pop_underflow     = pop_underflow_q;
    end

endmodule
